// File: rtl/adc_init_pkg.sv
// Shared definitions for the ADC init writer: FSM states, word layout and the
// default register table (addr/data pairs) that is programmed at power-up.
// No ports; imported by adc_init_rom and adc_init_writer.
package adc_init_pkg;

  localparam int ADC_ADDR_W   = 8;
  localparam int ADC_DATA_W   = 16;
  localparam int ADC_WORD_W   = ADC_ADDR_W + ADC_DATA_W;  // 24
  localparam int ADC_MAX_REGS = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_CS_SETUP = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_CS_HOLD  = 3'd4,
    ST_GAP      = 3'd5,
    ST_DONE     = 3'd6
  } adc_state_e;

  // One serial word: address byte goes out first (MSB first overall).
  typedef struct packed {
    logic [ADC_ADDR_W-1:0] addr;
    logic [ADC_DATA_W-1:0] data;
  } adc_reg_t;

  // Default power-up register table. Only the first NREG entries are used.
  function automatic adc_reg_t adc_init_reg(input logic [3:0] i);
    adc_reg_t r;
    case (i)
      4'd0:    r = {8'h00, 16'h8001};
      4'd1:    r = {8'h01, 16'h00A5};
      4'd2:    r = {8'h02, 16'h1234};
      4'd3:    r = {8'h05, 16'h00FF};
      4'd4:    r = {8'h08, 16'hA55A};
      4'd5:    r = {8'h14, 16'h0F0F};
      4'd6:    r = {8'h16, 16'hF0F0};
      4'd7:    r = {8'h18, 16'h7FFF};
      4'd8:    r = {8'h20, 16'h0000};
      4'd9:    r = {8'h21, 16'hFFFF};
      4'd10:   r = {8'h22, 16'h3C3C};
      4'd11:   r = {8'h23, 16'hC3C3};
      4'd12:   r = {8'h30, 16'h1111};
      4'd13:   r = {8'h31, 16'h2222};
      4'd14:   r = {8'h3E, 16'h4444};
      default: r = {8'hFF, 16'h0001};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adc_init_rom.sv
// Register table lookup: idx -> WORD_W-bit serial word, purely combinational.
// Latency: 0 cycles. Backpressure: none.
// Ports: idx (table index), word (addr/data word, MSB sent first).
module adc_init_rom
  import adc_init_pkg::*;
#(
  parameter int IDX_W  = 3,
  parameter int WORD_W = ADC_WORD_W
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  adc_reg_t entry;

  assign entry = adc_init_reg(4'(idx));
  assign word  = WORD_W'(entry);

endmodule

// File: rtl/adc_init_writer.sv
// Serially programs NREG config words into the ADC 3-wire port on each ADC_INIT rising edge.
// Latency: INIT_DONE rises NREG*(1+CLK_DIV*(2*WORD_W+3))+1 cycles after the sampling edge.
// Backpressure: none; ADC_INIT edges seen while a sequence runs are dropped.
// Ports: CLK/RST (sync, active high), ADC_INIT request in, BUSY/INIT_DONE status out,
//        ADC_CSB/ADC_SCLK/ADC_SDATA serial pins out (all outputs registered).
module adc_init_writer
  import adc_init_pkg::*;
#(
  parameter int NREG    = 8,
  parameter int WORD_W  = ADC_WORD_W,
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic ADC_INIT,
  output logic BUSY,
  output logic INIT_DONE,
  output logic ADC_CSB,
  output logic ADC_SCLK,
  output logic ADC_SDATA
);

  // A single-register table still needs a 1-bit index.
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int TW = $clog2(2 * CLK_DIV);

  localparam logic [IW-1:0] IDX_LAST  = IW'(NREG - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(2 * CLK_DIV - 1);

  adc_state_e        state, state_n;
  logic              init_q;
  logic              start;
  logic [TW-1:0]     timer, timer_n;
  logic [BW-1:0]     bcnt, bcnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [WORD_W-1:0] sh, sh_n;
  logic              sclk_hi, sclk_hi_n;
  logic [WORD_W-1:0] rom_word;

  logic busy_n, done_n, csb_n, sclk_n, sdata_n;

  adc_init_rom #(
    .IDX_W  (IW),
    .WORD_W (WORD_W)
  ) u_rom (
    .idx  (idx),
    .word (rom_word)
  );

  // init_q resets to 0, so a request already high when reset releases starts a sequence.
  assign start = ADC_INIT & ~init_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      init_q    <= 1'b0;
      timer     <= '0;
      bcnt      <= '0;
      idx       <= '0;
      sh        <= '0;
      sclk_hi   <= 1'b0;
      BUSY      <= 1'b0;
      INIT_DONE <= 1'b0;
      ADC_CSB   <= 1'b1;
      ADC_SCLK  <= 1'b0;
      ADC_SDATA <= 1'b0;
    end else begin
      state     <= state_n;
      init_q    <= ADC_INIT;
      timer     <= timer_n;
      bcnt      <= bcnt_n;
      idx       <= idx_n;
      sh        <= sh_n;
      sclk_hi   <= sclk_hi_n;
      BUSY      <= busy_n;
      INIT_DONE <= done_n;
      ADC_CSB   <= csb_n;
      ADC_SCLK  <= sclk_n;
      ADC_SDATA <= sdata_n;
    end
  end

  // Pin values are a function of the current state and get registered, so
  // every pin phase lags its state by one cycle but keeps its exact length.
  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bcnt_n    = bcnt;
    idx_n     = idx;
    sh_n      = sh;
    sclk_hi_n = sclk_hi;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    csb_n     = 1'b1;
    sclk_n    = 1'b0;
    sdata_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_n   = '0;
          state_n = ST_LOAD;
        end
      end

      ST_LOAD: begin
        busy_n  = 1'b1;
        sh_n    = rom_word;
        timer_n = '0;
        state_n = ST_CS_SETUP;
      end

      ST_CS_SETUP: begin
        busy_n  = 1'b1;
        csb_n   = 1'b0;
        sdata_n = sh[WORD_W-1];
        if (timer == HALF_LAST) begin
          timer_n   = '0;
          bcnt_n    = '0;
          sclk_hi_n = 1'b1;
          state_n   = ST_SHIFT;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      // Each bit is a high half-period followed (except for the last bit) by
      // a low half-period; the shift happens as the low phase begins so the
      // next bit has a full half-period of setup before the following rise.
      ST_SHIFT: begin
        busy_n  = 1'b1;
        csb_n   = 1'b0;
        sclk_n  = sclk_hi;
        sdata_n = sh[WORD_W-1];
        if (timer == HALF_LAST) begin
          timer_n = '0;
          if (!sclk_hi) begin
            sclk_hi_n = 1'b1;
            bcnt_n    = bcnt + 1'b1;
          end else if (bcnt == BIT_LAST) begin
            sclk_hi_n = 1'b0;
            state_n   = ST_CS_HOLD;
          end else begin
            sclk_hi_n = 1'b0;
            sh_n      = {sh[WORD_W-2:0], 1'b0};
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      ST_CS_HOLD: begin
        busy_n  = 1'b1;
        csb_n   = 1'b0;
        sdata_n = sh[WORD_W-1];
        if (timer == HALF_LAST) begin
          timer_n = '0;
          state_n = ST_GAP;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      ST_GAP: begin
        busy_n = 1'b1;
        if (timer == GAP_LAST) begin
          timer_n = '0;
          if (idx == IDX_LAST) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = ST_LOAD;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      ST_DONE: begin
        done_n = 1'b1;
        if (start) begin
          idx_n   = '0;
          state_n = ST_LOAD;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_adc_init_writer.sv
// Bench for adc_init_writer: a default instance (NREG=8, CLK_DIV=4) and a
// small one (NREG=1, CLK_DIV=2), serial pin monitors decoding words, and
// directed steps with randomized timing checked against timing/table rules.
module tb_adc_init_writer;

  localparam int NREG_D = 8;
  localparam int DIV_D  = 4;
  localparam int NREG_S = 1;
  localparam int DIV_S  = 2;
  localparam int WW     = 24;
  localparam int EXP_D  = NREG_D * (1 + DIV_D * (2 * WW + 3)) + 1;
  localparam int EXP_S  = NREG_S * (1 + DIV_S * (2 * WW + 3)) + 1;

  logic clk = 1'b0;
  logic rst;
  logic adc_init_d, busy_d, done_d, csb_d, sclk_d, sdata_d;
  logic adc_init_s, busy_s, done_s, csb_s, sclk_s, sdata_s;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_tab [16] = '{
    24'h008001, 24'h0100A5, 24'h021234, 24'h0500FF,
    24'h08A55A, 24'h140F0F, 24'h16F0F0, 24'h187FFF,
    24'h200000, 24'h21FFFF, 24'h223C3C, 24'h23C3C3,
    24'h301111, 24'h312222, 24'h3E4444, 24'hFF0001};

  always #5 clk = ~clk;

  adc_init_writer #(.NREG(NREG_D), .WORD_W(WW), .CLK_DIV(DIV_D)) dut (
    .CLK(clk), .RST(rst), .ADC_INIT(adc_init_d), .BUSY(busy_d), .INIT_DONE(done_d),
    .ADC_CSB(csb_d), .ADC_SCLK(sclk_d), .ADC_SDATA(sdata_d));

  adc_init_writer #(.NREG(NREG_S), .WORD_W(WW), .CLK_DIV(DIV_S)) dut_s (
    .CLK(clk), .RST(rst), .ADC_INIT(adc_init_s), .BUSY(busy_s), .INIT_DONE(done_s),
    .ADC_CSB(csb_s), .ADC_SCLK(sclk_s), .ADC_SDATA(sdata_s));

  // ---------------- serial monitor (index 0 = default, 1 = small) ----------
  typedef struct {
    int          id;
    logic [23:0] w;
    int          nb;
  } cap_t;

  cap_t        mon_q[$];
  logic [1:0]  csb_v, sclk_v, sdata_v;
  logic [1:0]  csb_p = 2'b11, sclk_p = 2'b00, sdata_p = 2'b00;
  logic [23:0] msh [2];
  int          mnb [2];
  int          last_chg [2] = '{-1000, -1000};
  int          last_rise [2] = '{-1000, -1000};
  int          div_v [2] = '{DIV_D, DIV_S};
  int          mcyc = 0;
  int          viol = 0;

  assign csb_v   = {csb_s, csb_d};
  assign sclk_v  = {sclk_s, sclk_d};
  assign sdata_v = {sdata_s, sdata_d};

  always @(negedge clk) begin
    cap_t c;
    mcyc++;
    for (int i = 0; i < 2; i++) begin
      if (!csb_v[i] && csb_p[i]) begin
        msh[i] = '0;
        mnb[i] = 0;
        last_chg[i] = mcyc;
      end else if (!csb_v[i] && (sdata_v[i] !== sdata_p[i])) begin
        if (mcyc - last_rise[i] < div_v[i]) viol++;
        last_chg[i] = mcyc;
      end
      if (!csb_v[i] && sclk_v[i] && !sclk_p[i]) begin
        if (mcyc - last_chg[i] < div_v[i]) viol++;
        last_rise[i] = mcyc;
        msh[i] = {msh[i][22:0], sdata_v[i]};
        mnb[i]++;
      end
      if (csb_v[i] && !csb_p[i]) begin
        c.id = i;
        c.w  = msh[i];
        c.nb = mnb[i];
        mon_q.push_back(c);
      end
    end
    csb_p   = csb_v;
    sclk_p  = sclk_v;
    sdata_p = sdata_v;
  end

  // ---------------- helpers -----------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_init(input bit sm, input logic v);
    if (sm) adc_init_s = v;
    else adc_init_d = v;
  endtask

  // Raises ADC_INIT so the next edge (k=0) samples the rise, keeps it high for
  // `width` sampled cycles, optionally re-raises it at cycle re_at, and times
  // INIT_DONE relative to that sampling edge.
  task automatic run_seq(input bit sm, input int width, input int re_at, input int limit,
                         output int done_k, output logic b0, output logic b1,
                         output logic d1, output int gaps, output logic busy_end);
    logic bz, dn;
    done_k = -1; gaps = 0; b0 = 1'bx; b1 = 1'bx; d1 = 1'bx; busy_end = 1'bx;
    @(posedge clk); #1 set_init(sm, 1'b1);
    for (int k = 0; k <= limit; k++) begin
      @(posedge clk);
      #1 set_init(sm, (k + 1 < width) || (re_at > 0 && k + 1 >= re_at && k + 1 < re_at + 3));
      @(negedge clk);
      bz = sm ? busy_s : busy_d;
      dn = sm ? done_s : done_d;
      if (k == 0) b0 = bz;
      if (k == 1) begin b1 = bz; d1 = dn; end
      if (k > 1 && dn) begin done_k = k; busy_end = bz; break; end
      if (k >= 1 && !bz) gaps++;
    end
    set_init(sm, 1'b0);
  endtask

  task automatic check_run(input string tag, input int done_k, input logic b0, input logic b1,
                           input int gaps, input logic busy_end, input int exp);
    chk({tag, "_busy_at_start_edge"}, 32'(b0), 32'd0);
    chk({tag, "_busy_next_cycle"}, 32'(b1), 32'd1);
    chk({tag, "_init_done_latency"}, done_k, exp);
    chk({tag, "_busy_drops"}, gaps, 0);
    chk({tag, "_busy_low_at_done"}, 32'(busy_end), 32'd0);
  endtask

  task automatic check_words(input int id, input int n);
    cap_t c;
    int got = 0;
    while (mon_q.size() > 0) begin
      c = mon_q.pop_front();
      if (c.id == id) begin
        if (got < n) begin
          chk($sformatf("word%0d_sclk_rises", got), c.nb, WW);
          chk($sformatf("word%0d_value", got), {8'h00, c.w}, {8'h00, exp_tab[got]});
        end
        got++;
      end
    end
    chk($sformatf("word_count_dut%0d", id), got, n);
  endtask

  // ---------------- directed steps ----------------------------------------
  initial begin
    int dk, gaps, w, re, t, drops;
    logic b0, b1, d1, be;

    rst = 1'b1; adc_init_d = 1'b0; adc_init_s = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy_d), 32'd0);
    chk("rst_init_done", 32'(done_d), 32'd0);
    chk("rst_csb", 32'(csb_d), 32'd1);
    chk("rst_sclk", 32'(sclk_d), 32'd0);
    chk("rst_sdata", 32'(sdata_d), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat ($urandom_range(3, 12)) @(posedge clk);

    // Single-cycle request pulse from Idle.
    run_seq(1'b0, 1, 0, EXP_D + 50, dk, b0, b1, d1, gaps, be);
    check_run("pulse", dk, b0, b1, gaps, be, EXP_D);
    check_words(0, NREG_D);
    drops = 0;
    repeat ($urandom_range(10, 30)) begin
      @(negedge clk);
      if (!done_d || !csb_d || busy_d) drops++;
    end
    chk("done_held_idle_pins", drops, 0);

    // Restart from Done, with a second rising edge while busy.
    w  = $urandom_range(2, 50);
    re = $urandom_range(400, 600);
    run_seq(1'b0, w, re, EXP_D + 50, dk, b0, b1, d1, gaps, be);
    chk("restart_done_low_next", 32'(d1), 32'd0);
    check_run("reedge", dk, b0, b1, gaps, be, EXP_D);
    check_words(0, NREG_D);

    // Reset in the middle of the sequence.
    w = $urandom_range(1, 100);
    t = $urandom_range(250, 350);
    @(posedge clk); #1 adc_init_d = 1'b1;
    repeat (w) @(posedge clk);
    #1 adc_init_d = 1'b0;
    repeat (t - w) @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", 32'(busy_d), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_csb", 32'(csb_d), 32'd1);
    chk("midrst_sclk", 32'(sclk_d), 32'd0);
    chk("midrst_busy", 32'(busy_d), 32'd0);
    chk("midrst_init_done", 32'(done_d), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_resume_after_rst", {30'd0, busy_d, csb_d}, 32'd1);
    mon_q.delete();
    run_seq(1'b0, $urandom_range(1, 20), 0, EXP_D + 50, dk, b0, b1, d1, gaps, be);
    check_run("after_rst", dk, b0, b1, gaps, be, EXP_D);
    check_words(0, NREG_D);

    // Request already high when reset releases counts as a rising edge.
    @(posedge clk); #1 rst = 1'b1; adc_init_d = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("held_high_out_of_reset_busy", 32'(busy_d), 32'd1);
    @(posedge clk); #1 rst = 1'b1; adc_init_d = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Small instance: one word, CLK_DIV=2, then a restart from Done.
    repeat ($urandom_range(2, 8)) @(posedge clk);
    run_seq(1'b1, 1, 0, EXP_S + 50, dk, b0, b1, d1, gaps, be);
    check_run("small", dk, b0, b1, gaps, be, EXP_S);
    check_words(1, NREG_S);
    repeat ($urandom_range(1, 10)) @(posedge clk);
    run_seq(1'b1, $urandom_range(1, 5), 0, EXP_S + 50, dk, b0, b1, d1, gaps, be);
    chk("small_restart_done_low_next", 32'(d1), 32'd0);
    check_run("small_restart", dk, b0, b1, gaps, be, EXP_S);
    check_words(1, NREG_S);

    chk("sdata_setup_hold_violations", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
